// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, req/ack fetch FSM and next-PC selection.
// Optional retire/redirect counters are built only when FETCH_PERF_CNT_EN is defined.
module instr_fetch_unit #(
   parameter int unsigned         ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   input  logic              stall,
   input  logic              Jmp,
   input  logic              Jumpinp,
   input  logic              PCsrc,
   input  logic [ADDR_W-1:0] jr_target,
   output logic [31:0]       instr,
   output logic [5:0]        opcode,
   output logic [5:0]        func,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic [31:0]       fetch_cnt,
   output logic [31:0]       redir_cnt
);

   typedef enum logic {FETCH, EXEC} state_t;

   state_t            state;
   logic [ADDR_W-1:0] next_pc;
   logic [ADDR_W-1:0] branch_off;
   logic              retire;
   logic              unused_jr_low;

   assign imem_addr     = pc;
   assign pc_plus4      = pc + ADDR_W'(4);
   assign opcode        = instr[31:26];
   assign func          = instr[5:0];
   assign retire        = (state == EXEC) && !stall;
   assign branch_off    = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
   assign unused_jr_low = &{1'b0, jr_target[1:0]};

   always_comb begin
      next_pc = pc_plus4;
      if (Jmp && Jumpinp)
         next_pc = {jr_target[ADDR_W-1:2], 2'b00};
      else if (Jmp)
         next_pc = {pc_plus4[ADDR_W-1:28], instr[25:0], 2'b00};
      else if (PCsrc)
         next_pc = pc_plus4 + branch_off;
   end

   // imem_req is registered: it rises one edge after reset release or retire,
   // so an ack in that first request cycle is accepted (zero-wait memory).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         instr       <= '0;
         instr_valid <= 1'b0;
         imem_req    <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (imem_req && imem_ack) begin
                  instr       <= imem_rdata;
                  imem_req    <= 1'b0;
                  instr_valid <= 1'b1;
                  state       <= EXEC;
               end else begin
                  imem_req <= 1'b1;
               end
            end
            EXEC: begin
               if (!stall) begin
                  pc          <= next_pc;
                  instr_valid <= 1'b0;
                  imem_req    <= 1'b1;
                  state       <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt <= '0;
         redir_cnt <= '0;
      end else if (retire) begin
         fetch_cnt <= fetch_cnt + 32'd1;
         if (Jmp || PCsrc)
            redir_cnt <= redir_cnt + 32'd1;
      end
   end
`else
   logic unused_retire;
   assign unused_retire = retire;
   assign fetch_cnt     = '0;
   assign redir_cnt     = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit against an arithmetic PC model.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        stall = 1'b0;
   logic        Jmp = 1'b0;
   logic        Jumpinp = 1'b0;
   logic        PCsrc = 1'b0;
   logic [31:0] jr_target = '0;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [5:0]  func;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] fetch_cnt;
   logic [31:0] redir_cnt;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [31:0] exp_pc = '0;
   logic [31:0] exp_fetch = '0;
   logic [31:0] exp_redir = '0;

   instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .Jmp(Jmp),
      .Jumpinp(Jumpinp), .PCsrc(PCsrc), .jr_target(jr_target), .instr(instr),
      .opcode(opcode), .func(func), .instr_valid(instr_valid), .pc(pc),
      .pc_plus4(pc_plus4), .fetch_cnt(fetch_cnt), .redir_cnt(redir_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                              input logic j, input logic ji, input logic br,
                                              input logic [31:0] jrt);
      logic [31:0]        p4;
      logic signed [15:0] imm;
      p4  = cur + 32'd4;
      imm = word[15:0];
      if (j && ji) return jrt & ~32'd3;
      if (j)       return (p4 & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
      if (br)      return p4 + 32'(int'(imm) * 4);
      return p4;
   endfunction

   task automatic check_counters();
`ifdef FETCH_PERF_CNT_EN
      check("fetch_cnt", fetch_cnt, exp_fetch);
      check("redir_cnt", redir_cnt, exp_redir);
`else
      check("fetch_cnt", fetch_cnt, 32'd0);
      check("redir_cnt", redir_cnt, 32'd0);
`endif
   endtask

   // Asynchronous reset entered mid-cycle; returns aligned with the first request cycle.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_pc", pc, 32'h0);
      check("rst_req", imem_req, 1'b0);
      check("rst_valid", instr_valid, 1'b0);
      check("rst_instr", instr, 32'h0);
      exp_pc = '0; exp_fetch = '0; exp_redir = '0;
      check_counters();
      tick();
      tick();
      rst_n = 1'b1;
      check("rel_req", imem_req, 1'b0);
      tick();
   endtask

   task automatic do_instr(input logic [31:0] word, input int unsigned waits,
                           input int unsigned stalls, input logic j, input logic ji,
                           input logic br, input logic [31:0] jrt, input logic rst_mid);
      logic [31:0] nxt;
      check("req", imem_req, 1'b1);
      check("addr", imem_addr, exp_pc);
      check("valid_fetch", instr_valid, 1'b0);
      for (int unsigned i = 0; i < waits; i++) begin
         stall = 1'($urandom); Jmp = 1'($urandom); PCsrc = 1'($urandom);
         tick();
         check("req_hold", imem_req, 1'b1);
         check("addr_hold", imem_addr, exp_pc);
         check("valid_wait", instr_valid, 1'b0);
      end
      imem_ack = 1'b1; imem_rdata = word;
      tick();
      imem_ack = 1'b0; imem_rdata = $urandom;
      check("valid", instr_valid, 1'b1);
      check("instr", instr, word);
      check("opcode", 32'(opcode), 32'(word[31:26]));
      check("func", 32'(func), 32'(word[5:0]));
      check("pc", pc, exp_pc);
      check("pc_plus4", pc_plus4, exp_pc + 32'd4);
      check("req_exec", imem_req, 1'b0);
      for (int unsigned i = 0; i < stalls; i++) begin
         stall = 1'b1; imem_ack = 1'($urandom);
         Jmp = 1'($urandom); Jumpinp = 1'($urandom); PCsrc = 1'($urandom);
         jr_target = $urandom;
         tick();
         imem_ack = 1'b0;
         check("stall_pc", pc, exp_pc);
         check("stall_instr", instr, word);
         check("stall_valid", instr_valid, 1'b1);
      end
      if (rst_mid) begin
         stall = 1'b0; Jmp = 1'b0; Jumpinp = 1'b0; PCsrc = 1'b0;
         do_reset();
         return;
      end
      stall = 1'b0; Jmp = j; Jumpinp = ji; PCsrc = br; jr_target = jrt;
      nxt = model_next(exp_pc, word, j, ji, br, jrt);
      tick();
      Jmp = 1'b0; Jumpinp = 1'b0; PCsrc = 1'b0; jr_target = $urandom;
      exp_pc = nxt;
      exp_fetch++;
      if (j || br) exp_redir++;
      check("valid_drop", instr_valid, 1'b0);
      check_counters();
   endtask

   initial begin
      #3;
      do_reset();
      // Zero-wait fetch of addi-like word; then sequential to 0x4
      do_instr(32'h2008_0005, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("seq_addr", imem_addr, 32'h4);
      // Three wait states, then jr to 0x10
      do_instr($urandom, 3, 0, 1'b1, 1'b1, 1'b0, 32'h10, 1'b0);
      do_instr(32'h1000_FFFE, 1, 0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
      check("branch_back", imem_addr, 32'h0C);
      do_instr($urandom, 0, 0, 1'b1, 1'b1, 1'b0, 32'h10, 1'b0);
      do_instr(32'h1000_FFFE, 0, 2, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("branch_not", imem_addr, 32'h14);
      do_instr($urandom, 0, 0, 1'b1, 1'b1, 1'b0, 32'h100, 1'b0);
      do_instr(32'h0800_0040, 2, 0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check("jump", imem_addr, 32'h100);
      do_instr($urandom, 0, 0, 1'b1, 1'b1, 1'b1, 32'h203, 1'b0);
      check("jr_wins", imem_addr, 32'h200);
      do_instr($urandom, 0, 0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0);
      do_instr(32'h0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("wrap", imem_addr, 32'h0);
      // Reset during a fetch wait, then during a stall
      tick();
      do_reset();
      check("restart_addr", imem_addr, 32'h0);
      do_instr($urandom, 1, 2, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      for (int unsigned n = 0; n < 250; n++) begin
         logic [31:0] w;
         w = $urandom;
         do_instr(w, $urandom_range(0, 3), $urandom_range(0, 2),
                  ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                  $urandom, ($urandom_range(0, 60) == 0));
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
